// File: rtl/pipe_exec_unit.sv
// Single-issue execute stage: registered ALU result plus branch/jump resolution.
// Define PIPE_EXEC_MUL_EN to build the serial shift-add multiplier for alu_op 10.
module pipe_exec_unit #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_op,
  input  logic [2:0]      br_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] offset,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SRL  = 4'd3;
  localparam logic [3:0] OP_SRA  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd3;
  localparam logic [2:0] BR_BGE  = 3'd4;
  localparam logic [2:0] BR_JAL  = 3'd5;
  localparam logic [2:0] BR_JALR = 3'd6;

  logic            r_out_valid;
  logic            r_redirect;
  logic [XLEN-1:0] r_result;
  logic [XLEN-1:0] r_redirect_pc;

  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_pc4;
  logic [XLEN-1:0] w_br_tgt;
  logic [XLEN-1:0] w_jsum;
  logic [XLEN-1:0] w_alu;
  logic [XLEN-1:0] w_res;
  logic [XLEN-1:0] w_target;
  logic            w_redir;
  logic            w_fire;
  logic            w_busy;
  logic            w_is_mul;
  logic            w_mul_done;
  logic [XLEN-1:0] w_mul_res;
  logic [XLEN-1:0] w_mul_pc4;

  assign w_shamt  = b[SHW-1:0];
  assign w_pc4    = pc + XLEN'(4);
  assign w_br_tgt = pc + offset;
  assign w_jsum   = a + offset;
  assign in_ready = !w_busy && (!r_out_valid || out_ready);
  assign w_fire   = in_valid && in_ready && !flush;

  always_comb begin
    w_alu = '0;
    case (alu_op)
      OP_ADD:  w_alu = a + b;
      OP_SUB:  w_alu = a - b;
      OP_SLL:  w_alu = a << w_shamt;
      OP_SRL:  w_alu = a >> w_shamt;
      OP_SRA:  w_alu = $signed(a) >>> w_shamt;
      OP_AND:  w_alu = a & b;
      OP_OR:   w_alu = a | b;
      OP_XOR:  w_alu = a ^ b;
      OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, a < b};
      default: w_alu = '0;
    endcase
  end

  // Branch conditions compare the raw operands, independent of alu_op.
  always_comb begin
    w_redir  = 1'b0;
    w_target = w_pc4;
    w_res    = w_alu;
    case (br_op)
      BR_BEQ:  w_redir = (a == b);
      BR_BNE:  w_redir = (a != b);
      BR_BLT:  w_redir = ($signed(a) < $signed(b));
      BR_BGE:  w_redir = ($signed(a) >= $signed(b));
      BR_JAL:  begin w_redir = 1'b1; w_res = w_pc4; end
      BR_JALR: begin w_redir = 1'b1; w_res = w_pc4; end
      default: w_redir = 1'b0;
    endcase
    if (w_redir)
      w_target = (br_op == BR_JALR) ? {w_jsum[XLEN-1:1], 1'b0} : w_br_tgt;
  end

`ifdef PIPE_EXEC_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_mpc4;
  logic [SHW-1:0]  r_cnt;
  logic [XLEN-1:0] w_acc_next;

  assign w_is_mul   = (alu_op == 4'd10);
  assign w_busy     = (r_state == S_RUN);
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  // Last iteration's partial sum goes straight to the output register.
  assign w_mul_done = w_busy && (r_cnt == '1);
  assign w_mul_res  = w_acc_next;
  assign w_mul_pc4  = r_mpc4;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_fire)
          w_next = w_is_mul ? S_RUN : S_IDLE;
        else if (r_state == S_DONE && out_ready)
          w_next = S_IDLE;
      end
      S_RUN:   if (w_mul_done) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_mpc4   <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      if (w_fire && w_is_mul) begin
        r_mcand  <= a;
        r_mplier <= b;
        r_acc    <= '0;
        r_mpc4   <= w_pc4;
        r_cnt    <= '0;
      end else if (w_busy) begin
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_acc    <= w_acc_next;
        r_cnt    <= r_cnt + 1'b1;
      end
    end
  end
`else
  assign w_is_mul   = 1'b0;
  assign w_busy     = 1'b0;
  assign w_mul_done = 1'b0;
  assign w_mul_res  = '0;
  assign w_mul_pc4  = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_redirect    <= 1'b0;
      r_result      <= '0;
      r_redirect_pc <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_redirect  <= 1'b0;
    end else if (w_mul_done) begin
      r_out_valid   <= 1'b1;
      r_result      <= w_mul_res;
      r_redirect    <= 1'b0;
      r_redirect_pc <= w_mul_pc4;
    end else if (w_fire) begin
      r_out_valid <= !w_is_mul;
      r_redirect  <= w_is_mul ? 1'b0 : w_redir;
      if (!w_is_mul) begin
        r_result      <= w_res;
        r_redirect_pc <= w_target;
      end
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign redirect    = r_redirect;
  assign redirect_pc = r_redirect_pc;

endmodule

// File: tb/tb_pipe_exec_unit.sv
// Directed + random bench for pipe_exec_unit; multiplier steps run when PIPE_EXEC_MUL_EN is defined.
module tb_pipe_exec_unit;
  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, redirect;
  logic [3:0]  alu_op;
  logic [2:0]  br_op;
  logic [31:0] a, b, pc, offset, result, redirect_pc;

  typedef struct packed {
    logic [31:0] res;
    logic        red;
    logic [31:0] rpc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipe_exec_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .br_op(br_op),
    .a(a), .b(b), .pc(pc), .offset(offset),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [2:0] br,
                                 input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] p, input logic [31:0] o);
    logic [31:0] r;
    logic        rd;
    logic [31:0] t;
    logic [4:0]  sh;
    sh = y[4:0];
    case (op)
      4'd0:  r = x + y;
      4'd1:  r = x - y;
      4'd2:  r = x << sh;
      4'd3:  r = x >> sh;
      4'd4:  r = (x >> sh) | (x[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      4'd5:  r = x & y;
      4'd6:  r = x | y;
      4'd7:  r = x ^ y;
      4'd8:  r = ((x[31] & ~y[31]) | ((x[31] == y[31]) & (x < y))) ? 32'd1 : 32'd0;
      4'd9:  r = (x < y) ? 32'd1 : 32'd0;
`ifdef PIPE_EXEC_MUL_EN
      4'd10: return '{res: x * y, red: 1'b0, rpc: p + 32'd4};
`endif
      default: r = 32'd0;
    endcase
    rd = 1'b0;
    t  = p + 32'd4;
    case (br)
      3'd1: rd = (x == y);
      3'd2: rd = (x != y);
      3'd3: rd = ($signed(x) < $signed(y));
      3'd4: rd = !($signed(x) < $signed(y));
      3'd5, 3'd6: begin rd = 1'b1; r = p + 32'd4; end
      default: rd = 1'b0;
    endcase
    if (rd) t = (br == 3'd6) ? ((x + o) & 32'hFFFF_FFFE) : (p + o);
    return '{res: r, red: rd, rpc: t};
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [2:0] br,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] p, input logic [31:0] o,
                       input exp_t e, input bit push);
    int n;
    n = 0;
    alu_op = op; br_op = br; a = x; b = y; pc = p; offset = o; in_valid = 1'b1;
    #0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("issue_ready", {31'd0, in_ready}, 32'd1);
    if (in_ready === 1'b1) begin
      if (push) sb.push_back(e);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      exp_t e;
      chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("redirect", {31'd0, redirect}, {31'd0, e.red});
        chk("redirect_pc", redirect_pc, e.rpc);
      end
    end
  end

  initial begin
    logic [3:0]  op;
    logic [2:0]  br;
    logic [31:0] x, y, p, o;
    int          seen, n;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = '0; br_op = '0; a = '0; b = '0; pc = '0; offset = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_redirect", {31'd0, redirect}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;

    issue(4'd0, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'd0, '{32'd0, 1'b0, 32'h204}, 1);
    chk("add_latency", {31'd0, out_valid}, 32'd1);
    issue(4'd4, 3'd0, 32'h8000_0000, 32'h21, 32'h300, 32'd0, '{32'hC000_0000, 1'b0, 32'h304}, 1);
    issue(4'd9, 3'd0, 32'd1, 32'hFFFF_FFFF, 32'h304, 32'd0, '{32'd1, 1'b0, 32'h308}, 1);
    issue(4'd0, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, '{32'd0, 1'b0, 32'h104}, 1);
    issue(4'd0, 3'd3, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, '{32'd0, 1'b1, 32'h120}, 1);
    issue(4'd0, 3'd6, 32'h1001, 32'd5, 32'h40, 32'd2, '{32'h44, 1'b1, 32'h1002}, 1);
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_result", result, 32'h44);
      chk("hold_rpc", redirect_pc, 32'h1002);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;

    issue(4'd11, 3'd0, 32'd5, 32'd6, 32'h10, 32'd0, '{32'd0, 1'b0, 32'h14}, 1);
    issue(4'd0, 3'd5, 32'd1, 32'd2, 32'h80, 32'hFFFF_FFF0, '{32'h84, 1'b1, 32'h70}, 1);
    issue(4'd0, 3'd7, 32'd3, 32'd3, 32'h90, 32'h40, '{32'd6, 1'b0, 32'h94}, 1);
    issue(4'd8, 3'd1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hA0, 32'h8, '{32'd0, 1'b1, 32'hA8}, 1);
`ifndef PIPE_EXEC_MUL_EN
    issue(4'd10, 3'd0, 32'd7, 32'd6, 32'h20, 32'd0, '{32'd0, 1'b0, 32'h24}, 1);
    chk("op10_latency", {31'd0, out_valid}, 32'd1);
`endif

    for (int i = 0; i < 16; i++) begin
      op = 4'($urandom_range(0, 15));
      br = 3'($urandom_range(0, 7));
      x  = $urandom;
      y  = (i % 4 == 0) ? x : $urandom;
      p  = $urandom & 32'hFFFF_FFFC;
      o  = $urandom;
      issue(op, br, x, y, p, o, model(op, br, x, y, p, o), 1);
    end

    // Flush coinciding with an output transfer: completes, new input ignored.
    issue(4'd7, 3'd0, 32'hF0F0, 32'h0FF0, 32'h50, 32'd0, '{32'hFF00, 1'b0, 32'h54}, 1);
    flush = 1'b1; in_valid = 1'b1; alu_op = 4'd0; a = 32'd1; b = 32'd1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_xfer_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("flush_no_output", {31'd0, out_valid}, 32'd0);

    // Flush of a held output with redirect set.
    issue(4'd5, 3'd1, 32'd9, 32'd9, 32'h60, 32'h10, '{32'd0, 1'b0, 32'd0}, 0);
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk("held_redirect", {31'd0, redirect}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_held_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_held_redirect", {31'd0, redirect}, 32'd0);
    out_ready = 1'b1;

    // Reset while an output is held.
    issue(4'd0, 3'd5, 32'd1, 32'd2, 32'h70, 32'h8, '{32'd0, 1'b0, 32'd0}, 0);
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_redirect", {31'd0, redirect}, 32'd0);
    chk("mid_rst_rpc", redirect_pc, 32'd0);
    out_ready = 1'b1;

`ifdef PIPE_EXEC_MUL_EN
    issue(4'd10, 3'd0, 32'd7, 32'd6, 32'h400, 32'd0, '{32'd42, 1'b0, 32'h404}, 1);
    for (int i = 0; i < 32; i++) begin
      chk("mul_busy_in_ready", {31'd0, in_ready}, 32'd0);
      chk("mul_busy_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
    end
    chk("mul_done_valid", {31'd0, out_valid}, 32'd1);
    issue(4'd10, 3'd5, 32'd3, 32'd5, 32'h500, 32'h100, '{32'd15, 1'b0, 32'h504}, 1);
    issue(4'd10, 3'd0, 32'd7, 32'd6, 32'h600, 32'd0, '{32'd0, 1'b0, 32'd0}, 0);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("mul_flush_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      if (out_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    chk("mul_flush_no_output", 32'(seen), 32'd0);
`endif

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_exec_unit.md
PIPE_EXEC_UNIT -- requirements
Module: pipe_exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (≥8, power of 2).
REQ-002 SHALL have parameter SHW, default $clog2(XLEN), shift-amount width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 flush  in  1  synchronous kill of in-flight and held work.
REQ-006 in_valid  in  1  operation offered; in_ready  out  1  unit can accept.
REQ-007 alu_op  in  4  0 add, 1 sub, 2 sll, 3 srl, 4 sra, 5 and, 6 or, 7 xor, 8 slt, 9 sltu, 10 mul; 11-15 reserved.
REQ-008 br_op  in  3  0 none, 1 beq, 2 bne, 3 blt, 4 bge, 5 jal, 6 jalr, 7 reserved (treated as none).
REQ-009 a, b, pc, offset  in  XLEN each  operands, instruction PC, sign-extended immediate.
REQ-010 out_valid  out  1  result held; out_ready  in  1  consumer accepts.
REQ-011 result  out  XLEN  ALU result, or pc+4 for jal/jalr.
REQ-012 redirect  out  1  taken branch/jump, qualified by out_valid; redirect_pc  out  XLEN  target.

Function
REQ-013 Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-014 in_ready SHALL equal !busy && (!out_valid || out_ready), busy being high only during a multiply.
REQ-015 Non-multiply ops SHALL appear on outputs exactly 1 cycle after input transfer (registered outputs).
REQ-016 Outputs SHALL hold stable while out_valid && !out_ready.
REQ-017 Arithmetic modulo 2^XLEN; shifts use b[SHW-1:0] only; sra arithmetic; slt signed, sltu unsigned, result 0 or 1.
REQ-018 Reserved alu_op SHALL yield result 0, no other effect.
REQ-019 Branch compare SHALL use a vs b directly (not ALU output): beq a==b, bne a!=b, blt signed a<b, bge signed a>=b.
REQ-020 Taken branch: redirect=1, redirect_pc=pc+offset; not taken: redirect=0, redirect_pc=pc+4.
REQ-021 jal: redirect=1, redirect_pc=pc+offset; jalr: redirect=1, redirect_pc=(a+offset) with bit 0 cleared; both result=pc+4.
REQ-022 br_op none/reserved: redirect=0, redirect_pc=pc+4.
REQ-023 flush SHALL clear out_valid, redirect and busy next cycle; in_valid in a flush cycle SHALL not be accepted.
REQ-024 flush with out_valid && out_ready same cycle: transfer counts as completed, no new output follows.

Reset
REQ-025 rst SHALL force out_valid=0, redirect=0, result=0, redirect_pc=0, busy=0, multiplier state IDLE, next cycle.
REQ-026 rst mid-multiply SHALL abandon it; no output is produced for it.
REQ-027 rst SHALL take priority over flush and input transfer.

Configuration
REQ-028 Macro PIPE_EXEC_MUL_EN SHALL compile in a serial shift-add multiplier for alu_op 10.
REQ-029 With macro: FSM IDLE->RUN on accept of op 10; RUN iterates XLEN cycles (one multiplier bit per cycle); RUN->DONE sets out_valid with low XLEN bits of a*b; total latency XLEN+1 cycles; busy=1 in RUN.
REQ-030 With macro: br_op on a multiply SHALL be ignored (redirect=0, redirect_pc=pc+4).
REQ-031 Without macro: op 10 SHALL behave as reserved (result 0, 1-cycle latency), busy tied 0, no multiplier logic.

Verification
REQ-032 XLEN=32, add a=0xFFFFFFFF b=1 -> next cycle out_valid=1, result=0, redirect=0, redirect_pc=pc+4.
REQ-033 sra a=0x80000000 b=0x21 -> result=0xC0000000; sltu a=1 b=0xFFFFFFFF -> result=1.
REQ-034 bge a=-1 b=1 pc=0x100 offset=0x20 -> redirect=0, redirect_pc=0x104; blt same -> redirect=1, redirect_pc=0x120.
REQ-035 jalr a=0x1001 offset=2 pc=0x40 -> redirect_pc=0x1002, result=0x44; out_ready=0 for 3 cycles -> outputs held, in_ready=0.
REQ-036 With PIPE_EXEC_MUL_EN: mul a=7 b=6 -> in_ready=0 for 32 cycles, result=42 at cycle 33; flush at cycle 10 -> no output, in_ready=1 next cycle.
